mem_swap_datapath: RTL

- Storage and datapath stage directly downstream of the memory-swap control FSM. It consumes that FSM's `sel[1:0]` and `w`.
- Holds two word-addressed memories, A and B, plus a temp register. Executes the 3-step exchange mem_a[addr_a] <-> mem_b[addr_b].
- Provides a host read/write port for loading and inspecting both memories while no swap is in progress.
- Signals completion with a one-cycle `done` pulse.

---
 rtl/mem_swap_datapath.sv | 114 +++++++++++
 1 files changed

// File: rtl/mem_swap_datapath.sv
// Storage and datapath for the memory-swap engine: two word memories, a temp
// register, and a host load/inspect port that is locked out while a swap is busy.
module mem_swap_datapath #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              swap,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [1:0]        sel,
    input  logic              w,
    input  logic              host_we,
    input  logic              host_msel,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic              host_err
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        STEP_IDLE  = 2'b00,
        STEP_LOAD  = 2'b01,
        STEP_MOVE  = 2'b10,
        STEP_STORE = 2'b11
    } step_t;

    step_t step;

    logic [DATA_W-1:0] mem_a [DEPTH];
    logic [DATA_W-1:0] mem_b [DEPTH];
    logic [DATA_W-1:0] temp;
    logic [ADDR_W-1:0] lat_a;
    logic [ADDR_W-1:0] lat_b;

    logic              a_we;
    logic              b_we;
    logic [ADDR_W-1:0] a_waddr;
    logic [ADDR_W-1:0] b_waddr;
    logic [DATA_W-1:0] a_wdata;
    logic [DATA_W-1:0] b_wdata;

    assign step = step_t'(sel);
    assign busy = w;

    // Swap steps own the write ports while w=1; the host only gets them when idle.
    always_comb begin
        a_we    = 1'b0;
        b_we    = 1'b0;
        a_waddr = '0;
        b_waddr = '0;
        a_wdata = '0;
        b_wdata = '0;
        if (w) begin
            case (step)
                STEP_MOVE: begin
                    a_we    = 1'b1;
                    a_waddr = lat_a;
                    a_wdata = mem_b[lat_b];
                end
                STEP_STORE: begin
                    b_we    = 1'b1;
                    b_waddr = lat_b;
                    b_wdata = temp;
                end
                default: ;
            endcase
        end else if (host_we) begin
            if (host_msel) begin
                b_we    = 1'b1;
                b_waddr = host_addr;
                b_wdata = host_wdata;
            end else begin
                a_we    = 1'b1;
                a_waddr = host_addr;
                a_wdata = host_wdata;
            end
        end
    end

    // Memories are not reset, so a step already committed survives a mid-swap abort.
    always_ff @(posedge clk) begin
        if (a_we) mem_a[a_waddr] <= a_wdata;
        if (b_we) mem_b[b_waddr] <= b_wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data  <= '0;
            done     <= 1'b0;
            host_err <= 1'b0;
            temp     <= '0;
            lat_a    <= '0;
            lat_b    <= '0;
        end else begin
            rd_data  <= host_msel ? mem_b[host_addr] : mem_a[host_addr];
            done     <= w && (step == STEP_STORE);
            host_err <= w && host_we;
            if (swap && !w && (step == STEP_IDLE)) begin
                lat_a <= addr_a;
                lat_b <= addr_b;
            end
            if (w && (step == STEP_LOAD)) begin
                temp <= mem_a[lat_a];
            end
        end
    end

endmodule
